// File: rtl/alu_mdu.sv
// Registered ALU with an iterative shift-add multiplier / restoring divider.
// Single-cycle ops finish one edge after acceptance; mult/div take WIDTH edges.
module alu_mdu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             zero,
  output logic             overflow,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADDU = 4'b0000, OP_SUBU = 4'b0001, OP_OR   = 4'b0010,
                         OP_ADD  = 4'b0011, OP_SLT  = 4'b0100, OP_LUI  = 4'b0101,
                         OP_AND  = 4'b0110, OP_XOR  = 4'b0111, OP_SLTU = 4'b1000,
                         OP_MULT = 4'b1010, OP_DIVU = 4'b1011,
                         OP_DIV  = 4'b1100, OP_MFHI = 4'b1101, OP_MFLO = 4'b1110;

  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_nx;

  logic [CW-1:0]    cnt;
  logic             md_div, sign_a, neg_q, dvz, eq_q;
  logic [WIDTH-1:0] a_raw, dvs, rem, quo;

  logic accept, is_md, is_signed, last;
  assign busy      = (state == BUSY);
  assign accept    = start && !busy;
  assign is_md     = (op >= 4'b1001) && (op <= 4'b1100);
  assign is_signed = (op == OP_MULT) || (op == OP_DIV);
  assign last      = busy && (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept && is_md) state_nx = BUSY;
      BUSY: if (last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Single-cycle ALU
  logic [WIDTH-1:0] sum, alu_res;
  logic             add_ovf;
  assign sum     = a + b;
  assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADDU: alu_res = sum;
      OP_SUBU: alu_res = a - b;
      OP_OR:   alu_res = a | b;
      OP_ADD:  alu_res = add_ovf ? '0 : sum;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_LUI:  alu_res = b;
      OP_AND:  alu_res = a & b;
      OP_XOR:  alu_res = a ^ b;
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_MFHI: alu_res = hi;
      OP_MFLO: alu_res = lo;
      default: alu_res = '0;
    endcase
  end

  // Operand magnitudes; signs are reapplied on the last step
  logic [WIDTH-1:0] neg_a, neg_b, mag_a, mag_b;
  assign neg_a = -a;
  assign neg_b = -b;
  assign mag_a = (is_signed && a[WIDTH-1]) ? neg_a : a;
  assign mag_b = (is_signed && b[WIDTH-1]) ? neg_b : b;

  // One iteration: rem holds the upper half / partial remainder, quo the lower half / quotient
  logic [WIDTH:0]   add_sum, shl, diff;
  logic [WIDTH-1:0] rem_nx, quo_nx;
  assign add_sum = {1'b0, rem} + {1'b0, dvs};
  assign shl     = {rem, quo[WIDTH-1]};
  assign diff    = shl - {1'b0, dvs};

  always_comb begin
    rem_nx = rem;
    quo_nx = quo;
    if (!md_div) begin
      if (quo[0]) {rem_nx, quo_nx} = {add_sum, quo[WIDTH-1:1]};
      else        {rem_nx, quo_nx} = {1'b0, rem, quo[WIDTH-1:1]};
    end else if (!diff[WIDTH]) begin
      rem_nx = diff[WIDTH-1:0];
      quo_nx = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_nx = shl[WIDTH-1:0];
      quo_nx = {quo[WIDTH-2:0], 1'b0};
    end
  end

  logic [2*WIDTH-1:0] prod, prod_neg;
  logic [WIDTH-1:0]   q_neg, r_neg, fin_hi, fin_lo;
  assign prod     = {rem_nx, quo_nx};
  assign prod_neg = -prod;
  assign q_neg    = -quo_nx;
  assign r_neg    = -rem_nx;

  always_comb begin
    if (!md_div) begin
      {fin_hi, fin_lo} = neg_q ? prod_neg : prod;
    end else if (dvz) begin
      fin_hi = a_raw;
      fin_lo = '1;
    end else begin
      fin_hi = sign_a ? r_neg : rem_nx;
      fin_lo = neg_q  ? q_neg : quo_nx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result <= '0; hi <= '0; lo <= '0;
      zero <= 1'b0; overflow <= 1'b0; done <= 1'b0;
      cnt <= '0; md_div <= 1'b0; sign_a <= 1'b0; neg_q <= 1'b0; dvz <= 1'b0; eq_q <= 1'b0;
      a_raw <= '0; dvs <= '0; rem <= '0; quo <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        if (is_md) begin
          md_div <= (op == OP_DIVU) || (op == OP_DIV);
          sign_a <= is_signed && a[WIDTH-1];
          neg_q  <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
          dvz    <= (b == '0);
          eq_q   <= (a == b);
          a_raw  <= a;
          dvs    <= mag_b;
          rem    <= '0;
          quo    <= mag_a;
          cnt    <= '0;
        end else begin
          result   <= alu_res;
          zero     <= (a == b);
          overflow <= (op == OP_ADD) && add_ovf;
          done     <= 1'b1;
        end
      end
      if (busy) begin
        rem <= rem_nx;
        quo <= quo_nx;
        cnt <= cnt + 1'b1;
        if (last) begin
          hi       <= fin_hi;
          lo       <= fin_lo;
          result   <= fin_lo;
          zero     <= eq_q;
          overflow <= 1'b0;
          done     <= 1'b1;
          cnt      <= '0;
        end
      end
    end
  end
endmodule

// File: doc/alu_mdu.md
# alu_mdu

Parametrised, registered ALU with an iterative multiply/divide unit and HI/LO registers, replacing the purely combinational ALU in the multi-cycle datapath. Single-cycle ops (add/sub/logic/compare/lui/mfhi/mflo) complete one clock after acceptance. Multiply/divide run a WIDTH-step shift-add/restoring-divide sequence. The control unit issues ops with a start/busy/done handshake.

## Interface
- WIDTH, 32: operand/result width; must be ≥ 4.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  request; accepted on an edge where start=1 and busy=0.
- op  in  4  operation code, sampled at acceptance.
- a, b  in  WIDTH  operands, sampled at acceptance.
- result  out  WIDTH  registered result.
- hi, lo  out  WIDTH  HI/LO registers.
- zero  out  1  registered (a == b) of the accepted op.
- overflow  out  1  registered signed-add overflow.
- busy  out  1  mult/div in progress.
- done  out  1  one-cycle pulse: result/hi/lo/zero/overflow valid.

## Operation
- Op codes:
  - 0000 addu; 0001 subu; 0010 or; 0011 add (signed, checked); 0100 slt (signed); 0101 lui (result = b).
  - 0110 and; 0111 xor; 1000 sltu.
  - 1001 multu; 1010 mult; 1011 divu; 1100 div.
  - 1101 mfhi (result = hi); 1110 mflo (result = lo); 1111 reserved (result = 0).
- add: overflow = carry into the sign bit differs from carry out. On overflow, result = 0 and overflow = 1. overflow is cleared on every other accepted op.
- slt/sltu: result is 1 or 0, zero-extended to WIDTH.
- zero = (a == b) for every accepted op, registered with result.
- States: IDLE, BUSY.
  - IDLE → BUSY on acceptance of ops 1001–1100.
  - All other accepted ops stay in IDLE.
  - BUSY → IDLE after the WIDTH-th step.
- mult/div signed handling: operate on magnitudes, then sign-correct in the final step.
- {hi, lo} = full 2·WIDTH product.
- div: lo = quotient (truncated toward zero); hi = remainder (same sign as dividend).
- Divide by zero (signed or unsigned): hi = a, lo = all ones. Normal latency applies.
- Signed div of the most-negative value by −1: lo = most-negative value, hi = 0.
- On mult/div completion, result = lo.
- hi/lo change only on mult/div completion.
- start while busy=1 is ignored: no queueing, no effect on the running op.
- Outputs hold their values until the next completion.

## Timing
- Reset (asynchronous, immediate):
  - result, hi, lo = 0; zero, overflow, busy, done = 0; state = IDLE; step counter = 0.
  - Reset during BUSY aborts the op. No done pulse is issued and hi/lo read 0.
- Single-cycle op accepted at edge E0:
  - result, zero, overflow updated at E0.
  - done = 1 for the cycle following E0, then returns to 0 at E1 unless another op completes.
- Mult/div accepted at edge E0:
  - busy = 1 from E0.
  - One step per edge at E1…E(WIDTH).
  - At E(WIDTH): busy → 0, done → 1, hi/lo/result updated. Latency = WIDTH edges.
- A new start may be accepted in the cycle done is high (busy = 0), so back-to-back ops are allowed.
- mfhi/mflo accepted in the cycle done is high read the just-completed hi/lo values.
- done is never high while busy is high.

## Test plan
- add 0x7FFFFFFF + 0x00000001 → result 0, overflow 1, done after 1 edge. Same operands with addu → 0x80000000, overflow 0.
- multu 0xFFFFFFFF × 0xFFFFFFFF → busy for 32 cycles; done at edge E32; hi 0xFFFFFFFE, lo 0x00000001, result 0x00000001.
- div 0xFFFFFFF9 (−7) / 0x00000002 → lo 0xFFFFFFFD, hi 0xFFFFFFFF. div 0x80000000 / 0xFFFFFFFF → lo 0x80000000, hi 0.
- divu 0x00000005 / 0 → hi 0x00000005, lo 0xFFFFFFFF, done at E32.
- mult issued, then start with op add during busy → ignored: result unchanged until mult completes, exactly one done pulse. slt 0xFFFFFFFF, 1 → result 1; sltu with the same operands → result 0; zero = 0 for both.
- Reset asserted mid-mult, 10 cycles after acceptance → busy, done, hi, lo, result all 0 immediately. A subsequent mfhi returns 0, and a following multu 3 × 4 gives lo 12.
